// File: rtl/slow_memory_cache_pkg.sv
// Shared constants and state encoding for the direct-mapped write-through cache.
package slow_memory_cache_pkg;

    localparam int WORD_BITS       = 32;
    localparam int WORD_SIZE_BYTES = 4;
    localparam int LINES           = 16;
    localparam int INDEX_BITS      = 4;
    localparam int OFFSET_BITS     = 2;
    localparam int TAG_BITS        = WORD_BITS - INDEX_BITS - OFFSET_BITS;

    // Bit positions of the address fields: [TAG_MSB:TAG_LSB] tag, [IDX_MSB:IDX_LSB] index
    localparam int IDX_LSB = OFFSET_BITS;
    localparam int IDX_MSB = OFFSET_BITS + INDEX_BITS - 1;
    localparam int TAG_LSB = OFFSET_BITS + INDEX_BITS;
    localparam int TAG_MSB = WORD_BITS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/slow_memory_cache_array.sv
// Valid/tag/data storage: combinational lookup, one write port.
// Only the valid bits are reset; tag and data contents are meaningless until validated.
module slow_memory_cache_array
    import slow_memory_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [TAG_BITS-1:0]   rd_tag_i,
    output logic                  hit_o,
    output logic [WORD_BITS-1:0]  rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [WORD_BITS-1:0]  wr_data_i
);

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [WORD_BITS-1:0] data_q [LINES];

    assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i];

    // Valid bits: cleared on reset, set by any line write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage, no reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/slow_memory_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of a
// slow start/ready memory. Read hits complete in one cycle; read misses and
// all writes run one bus transaction with address/data held stable.
module slow_memory_cache
    import slow_memory_cache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_busy,
    output logic        memory_start,
    input  logic        memory_rdy,
    output logic        memory_write_enable,
    output logic [31:0] memory_address,
    inout  wire  [31:0] memory_data
);

    state_e                state_q;
    logic                  ack_q;
    logic [WORD_BITS-1:0]  rdata_q;
    logic                  start_q;
    logic                  we_q;
    logic [WORD_BITS-1:0]  addr_q;
    logic [WORD_BITS-1:0]  wdata_q;

    logic                  hit;
    logic [WORD_BITS-1:0]  arr_rdata;
    logic                  arr_wr_en;
    logic [INDEX_BITS-1:0] arr_wr_idx;
    logic [TAG_BITS-1:0]   arr_wr_tag;
    logic [WORD_BITS-1:0]  arr_wr_data;

    slow_memory_cache_array u_array (
        .clk       (clk),
        .rst_n     (reset),
        .rd_idx_i  (cpu_addr[IDX_MSB:IDX_LSB]),
        .rd_tag_i  (cpu_addr[TAG_MSB:TAG_LSB]),
        .hit_o     (hit),
        .rd_data_o (arr_rdata),
        .wr_en_i   (arr_wr_en),
        .wr_idx_i  (arr_wr_idx),
        .wr_tag_i  (arr_wr_tag),
        .wr_data_i (arr_wr_data)
    );

    // Array write source: write hit updates in place from the CPU; a read miss
    // fills the line from the bus when memory reports ready.
    always_comb begin
        arr_wr_en   = 1'b0;
        arr_wr_idx  = cpu_addr[IDX_MSB:IDX_LSB];
        arr_wr_tag  = cpu_addr[TAG_MSB:TAG_LSB];
        arr_wr_data = cpu_wdata;
        if (state_q == IDLE && cpu_req && cpu_we && hit) begin
            arr_wr_en = 1'b1;
        end else if (state_q == WAIT && memory_rdy && !we_q) begin
            arr_wr_en   = 1'b1;
            arr_wr_idx  = addr_q[IDX_MSB:IDX_LSB];
            arr_wr_tag  = addr_q[TAG_MSB:TAG_LSB];
            arr_wr_data = memory_data;
        end
    end

    // Control FSM with registered CPU and bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (cpu_req) begin
                        if (!cpu_we && hit) begin
                            rdata_q <= arr_rdata;
                            ack_q   <= 1'b1;
                        end else begin
                            // Word-align by masking so the whole address bus is consumed
                            addr_q  <= cpu_addr & ~32'h3;
                            wdata_q <= cpu_wdata;
                            we_q    <= cpu_we;
                            start_q <= 1'b1;
                            state_q <= START;
                        end
                    end
                end
                START: begin
                    // Hold the start strobe until the memory is ready to accept it
                    if (memory_rdy) begin
                        start_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (memory_rdy) begin
                        if (!we_q) begin
                            rdata_q <= memory_data;
                        end
                        we_q    <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack             = ack_q;
    assign cpu_rdata           = rdata_q;
    assign cpu_busy            = (state_q != IDLE);
    assign memory_start        = start_q;
    assign memory_write_enable = we_q;
    assign memory_address      = addr_q;
    assign memory_data         = we_q ? wdata_q : 32'bz;

endmodule

// File: tb/tb_slow_memory_cache.sv
// Scoreboard bench for slow_memory_cache with a 5-cycle slow memory model.
module tb_slow_memory_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_busy;
    logic        memory_start;
    logic        memory_rdy;
    logic        memory_write_enable;
    logic [31:0] memory_address;
    wire  [31:0] memory_data;

    always #5 clk = ~clk;

    slow_memory_cache dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_req             (cpu_req),
        .cpu_we              (cpu_we),
        .cpu_addr            (cpu_addr),
        .cpu_wdata           (cpu_wdata),
        .cpu_rdata           (cpu_rdata),
        .cpu_ack             (cpu_ack),
        .cpu_busy            (cpu_busy),
        .memory_start        (memory_start),
        .memory_rdy          (memory_rdy),
        .memory_write_enable (memory_write_enable),
        .memory_address      (memory_address),
        .memory_data         (memory_data)
    );

    // ---------------- slow memory model (environment) ----------------
    localparam int MEM_WORDS = 4096;
    logic [31:0] mem_store [MEM_WORDS];
    logic        mem_drive;
    logic [31:0] mem_out;
    int          mem_cnt;
    logic [11:0] mem_waddr;
    logic        mem_rd;

    assign memory_data = mem_drive ? mem_out : 32'bz;

    function automatic logic [31:0] init_word(input int w);
        logic [31:0] v;
        v = w;
        return (v * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            memory_rdy <= 1'b1;
            mem_drive  <= 1'b0;
            mem_cnt    <= 0;
        end else begin
            mem_drive <= 1'b0;
            if (memory_rdy && memory_start) begin
                memory_rdy <= 1'b0;
                mem_cnt    <= 4;
                mem_waddr  <= memory_address[13:2];
                mem_rd     <= !memory_write_enable;
                if (memory_write_enable)
                    mem_store[memory_address[13:2]] <= memory_data;
            end else if (!memory_rdy) begin
                if (mem_cnt == 0) begin
                    memory_rdy <= 1'b1;
                    if (mem_rd) begin
                        mem_drive <= 1'b1;
                        mem_out   <= mem_store[mem_waddr];
                    end
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          issue_cyc;
    } item_t;

    item_t       sbq[$];
    logic [31:0] ref_mem   [MEM_WORDS];
    bit          ref_valid [16];
    logic [25:0] ref_tag   [16];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int starts_seen = 0;
    int exp_starts = 0;
    int acks_seen = 0;
    int acks_target = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_store[i] = init_word(i);
            ref_mem[i]   = init_word(i);
        end
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare everything the DUT presents against the queue head
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (memory_start) starts_seen++;
            if (cpu_ack) begin
                if (sbq.size() == 0) begin
                    check32("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    item_t it;
                    logic [3:0] idx;
                    it = sbq.pop_front();
                    check32("ack_latency", cyc - it.issue_cyc, it.lat);
                    check32("we_low_at_ack", {31'd0, memory_write_enable}, 32'd0);
                    if (!it.we) begin
                        check32("rdata", cpu_rdata, it.rdata);
                        if (it.lat != 1) begin
                            idx = it.addr[5:2];
                            ref_valid[idx] = 1'b1;
                            ref_tag[idx]   = it.addr[31:6];
                        end
                    end
                end
                acks_seen++;
            end else if (cpu_busy && sbq.size() > 0) begin
                check32("mem_address", memory_address, sbq[0].addr & ~32'h3);
                check32("mem_we", {31'd0, memory_write_enable}, {31'd0, sbq[0].we});
                if (sbq[0].we) check32("mem_wdata", memory_data, sbq[0].wdata);
            end
        end
    end

    // Issue one request, hold cpu_req for 'hold' cycles, then wait for its ack
    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold);
        item_t it;
        logic [3:0] idx;
        logic hit;
        int w;
        int t;
        @(posedge clk); #1;
        idx = addr[5:2];
        w   = int'(addr[13:2]);
        hit = !we && ref_valid[idx] && (ref_tag[idx] == addr[31:6]);
        it.we        = we;
        it.addr      = addr;
        it.wdata     = wdata;
        it.rdata     = ref_mem[w];
        it.lat       = hit ? 1 : 8;
        it.issue_cyc = cyc;
        if (we) ref_mem[w] = wdata;
        if (!hit) exp_starts++;
        sbq.push_back(it);
        acks_target++;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        repeat (hit ? 1 : hold) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        t = 0;
        while (acks_seen < acks_target && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (acks_seen < acks_target) begin
            check32("ack_timeout", acks_seen, acks_target);
            sbq.delete();
            acks_seen = acks_target;
        end
    endtask

    initial begin
        int sp;
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_ack",   {31'd0, cpu_ack}, 32'd0);
        check32("rst_rdata", cpu_rdata, 32'd0);
        check32("rst_busy",  {31'd0, cpu_busy}, 32'd0);
        check32("rst_start", {31'd0, memory_start}, 32'd0);
        check32("rst_we",    {31'd0, memory_write_enable}, 32'd0);
        check32("rst_addr",  memory_address, 32'd0);
        reset = 1'b1;

        // Miss then hit on the same word
        do_op(1'b0, 32'h10, 32'h0, 1);
        sp = starts_seen;
        do_op(1'b0, 32'h10, 32'h0, 1);
        check32("hit_no_start", starts_seen, sp);

        // Write miss does not allocate; following read misses and sees new data
        do_op(1'b1, 32'h20, 32'hDEAD_BEEF, 1);
        do_op(1'b0, 32'h20, 32'h0, 1);

        // Aliasing on index 1
        do_op(1'b0, 32'h04, 32'h0, 1);
        do_op(1'b0, 32'h44, 32'h0, 1);
        do_op(1'b0, 32'h04, 32'h0, 1);

        // Write hit updates cache and memory
        do_op(1'b1, 32'h10, 32'h1234_5678, 1);
        do_op(1'b0, 32'h10, 32'h0, 1);

        // Request held high across a miss: exactly one transaction
        sp = starts_seen;
        do_op(1'b0, 32'h84, 32'h0, 6);
        check32("held_req_starts", starts_seen - sp, 32'd1);

        // Reset in the middle of a read miss
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h300;
        exp_starts++;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check32("abort_start", {31'd0, memory_start}, 32'd0);
        check32("abort_we",    {31'd0, memory_write_enable}, 32'd0);
        check32("abort_busy",  {31'd0, cpu_busy}, 32'd0);
        check32("abort_addr",  memory_address, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        do_op(1'b0, 32'h300, 32'h0, 1);

        // Randomized traffic over a small address pool to mix hits, misses and aliasing
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic        w;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            w = ($urandom_range(0, 9) < 4);
            do_op(w, a, $urandom, $urandom_range(1, 5));
        end

        repeat (3) @(posedge clk);
        check32("start_count", starts_seen, exp_starts);
        check32("queue_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
